// File: rtl/vga_sync_gen.sv
// VGA timing source: divides the system clock to a pixel tick and produces the
// pixel coordinates, blanking flag, registered sync pulses and frame marker.
module vga_sync_gen #(
    parameter int unsigned HD  = 640,
    parameter int unsigned HF  = 16,
    parameter int unsigned HR  = 96,
    parameter int unsigned HB  = 48,
    parameter int unsigned VD  = 480,
    parameter int unsigned VF  = 10,
    parameter int unsigned VR  = 2,
    parameter int unsigned VB  = 33,
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DivLast  = DW'(DIV - 1);
    localparam logic [9:0]    HMax     = 10'(HD + HF + HR + HB - 1);
    localparam logic [9:0]    VMax     = 10'(VD + VF + VR + VB - 1);
    localparam logic [9:0]    HVis     = 10'(HD);
    localparam logic [9:0]    VVis     = 10'(VD);
    localparam logic [9:0]    HsStart  = 10'(HD + HF);
    localparam logic [9:0]    HsEnd    = 10'(HD + HF + HR - 1);
    localparam logic [9:0]    VsStart  = 10'(VD + VF);
    localparam logic [9:0]    VsEnd    = 10'(VD + VF + VR - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;
    logic          h_end, v_end;

    always_comb begin
        p_tick    = (div_cnt_q == DivLast);
        div_cnt_d = p_tick ? '0 : div_cnt_q + 1'b1;
        h_end     = (h_q == HMax);
        v_end     = (v_q == VMax);

        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            h_d = h_end ? 10'd0 : h_q + 10'd1;
            if (h_end) begin
                v_d = v_end ? 10'd0 : v_q + 10'd1;
            end
        end

        // Syncs decode the next-state counters so they move on the same edge as pixel_x/y.
        hsync_d       = !((h_d >= HsStart) && (h_d <= HsEnd));
        vsync_d       = !((v_d >= VsStart) && (v_d <= VsEnd));
        frame_start_d = p_tick && h_end && v_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign video_on    = (h_q < HVis) && (v_q < VVis);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-timing instance for frame-level behaviour and a
// default 640x480 instance for line-level behaviour, both checked against elapsed-time arithmetic.
module tb_vga_sync_gen;

    localparam int unsigned SHD = 16, SHF = 4, SHR = 6, SHB = 4;
    localparam int unsigned SVD = 10, SVF = 2, SVR = 2, SVB = 3;
    localparam int unsigned SDIV = 4;
    localparam int unsigned SHTOT = SHD + SHF + SHR + SHB;
    localparam int unsigned SVTOT = SVD + SVF + SVR + SVB;
    localparam int unsigned SFRAME = SHTOT * SVTOT * SDIV;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       s_hs, s_vs, s_von, s_pt, s_fs;
    logic [9:0] s_x, s_y;
    logic       d_hs, d_vs, d_von, d_pt, d_fs;
    logic [9:0] d_x, d_y;

    int unsigned n = 0;
    int checks = 0;
    int errors = 0;

    vga_sync_gen #(
        .HD(SHD), .HF(SHF), .HR(SHR), .HB(SHB),
        .VD(SVD), .VF(SVF), .VR(SVR), .VB(SVB), .DIV(SDIV)
    ) dut (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs)
    );

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since reset was last sampled high.
    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic exp_t model(input int unsigned cyc, input int unsigned hd, input int unsigned hf,
                                   input int unsigned hr, input int unsigned hb, input int unsigned vd,
                                   input int unsigned vf, input int unsigned vr, input int unsigned vb,
                                   input int unsigned dv);
        exp_t e;
        int unsigned htot, vtot, t, p, h, v;
        htot  = hd + hf + hr + hb;
        vtot  = vd + vf + vr + vb;
        t     = cyc / dv;
        p     = t % (htot * vtot);
        h     = p % htot;
        v     = p / htot;
        e.x   = 10'(h);
        e.y   = 10'(v);
        e.hs  = !(h >= hd + hf && h < hd + hf + hr);
        e.vs  = !(v >= vd + vf && v < vd + vf + vr);
        e.von = (h < hd) && (v < vd);
        e.pt  = (cyc % dv) == dv - 1;
        e.fs  = (cyc > 0) && (cyc % dv == 0) && (t % (htot * vtot) == 0);
        return e;
    endfunction

    function automatic exp_t model_s(input int unsigned cyc);
        return model(cyc, SHD, SHF, SHR, SHB, SVD, SVF, SVR, SVB, SDIV);
    endfunction

    function automatic exp_t model_d(input int unsigned cyc);
        return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    endfunction

    task automatic test_reset();
        exp_t a, b;
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            a = {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs};
            b = {d_x, d_y, d_hs, d_vs, d_von, d_pt, d_fs};
            checks++;
            if (a !== {10'd0, 10'd0, 5'b11100}) begin
                errors++;
                $display("FAIL reset_small got %h want %h", a, {10'd0, 10'd0, 5'b11100});
            end
            checks++;
            if (b !== {10'd0, 10'd0, 5'b11100}) begin
                errors++;
                $display("FAIL reset_default got %h want %h", b, {10'd0, 10'd0, 5'b11100});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_tick_spacing();
        exp_t e;
        repeat (3 * SDIV) begin
            @(negedge clk);
            e = model_s(n);
            checks++;
            if (s_pt !== e.pt || s_x !== e.x) begin
                errors++;
                $display("FAIL tick_spacing n=%0d got pt=%b x=%0d want pt=%b x=%0d",
                         n, s_pt, s_x, e.pt, e.x);
            end
        end
    endtask

    task automatic test_hsync_line();
        exp_t e;
        repeat (800 * 4 + 16) begin
            @(negedge clk);
            e = model_d(n);
            checks++;
            if (d_hs !== e.hs || d_von !== e.von || d_x !== e.x || d_pt !== e.pt) begin
                errors++;
                $display("FAIL hsync_line n=%0d got hs=%b von=%b x=%0d pt=%b want hs=%b von=%b x=%0d pt=%b",
                         n, d_hs, d_von, d_x, d_pt, e.hs, e.von, e.x, e.pt);
            end
        end
    endtask

    task automatic test_line_wrap();
        exp_t e;
        int guard = 0;
        e = model_s(n);
        while (!(e.x == 10'(SHTOT - 1) && e.y == 10'd5 && e.pt) && guard < 2 * SFRAME) begin
            @(negedge clk);
            e = model_s(n);
            guard++;
        end
        checks++;
        if (s_x !== 10'(SHTOT - 1) || s_y !== 10'd5 || s_pt !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap_pre got x=%0d y=%0d pt=%b want x=%0d y=5 pt=1",
                     s_x, s_y, s_pt, SHTOT - 1);
        end
        @(negedge clk);
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'd6 || s_fs !== 1'b0) begin
            errors++;
            $display("FAIL line_wrap_post got x=%0d y=%0d fs=%b want x=0 y=6 fs=0", s_x, s_y, s_fs);
        end
    endtask

    task automatic test_vsync();
        exp_t e;
        logic prev_vs;
        int falls = 0;
        prev_vs = s_vs;
        repeat (SFRAME + 8) begin
            @(negedge clk);
            e = model_s(n);
            checks++;
            if (s_vs !== e.vs || s_von !== e.von || s_y !== e.y || s_x !== e.x) begin
                errors++;
                $display("FAIL vsync n=%0d got vs=%b von=%b x=%0d y=%0d want vs=%b von=%b x=%0d y=%0d",
                         n, s_vs, s_von, s_x, s_y, e.vs, e.von, e.x, e.y);
            end
            if (prev_vs === 1'b1 && s_vs === 1'b0) begin
                falls++;
                checks++;
                if (s_x !== 10'd0 || s_y !== 10'(SVD + SVF)) begin
                    errors++;
                    $display("FAIL vsync_fall got x=%0d y=%0d want x=0 y=%0d", s_x, s_y, SVD + SVF);
                end
            end
            prev_vs = s_vs;
        end
        checks++;
        if (falls != 1) begin
            errors++;
            $display("FAIL vsync_fall_count got %0d want 1", falls);
        end
    endtask

    task automatic test_frame_wrap();
        int cnt = 0;
        while (s_fs !== 1'b1 && cnt < 2 * SFRAME) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (s_fs !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0) begin
            errors++;
            $display("FAIL frame_start_seen got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", s_fs, s_x, s_y);
        end
        cnt = 0;
        @(negedge clk);
        cnt++;
        checks++;
        if (s_fs !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width got fs=%b want 0", s_fs);
        end
        while (s_fs !== 1'b1 && cnt < 2 * SFRAME) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != SFRAME) begin
            errors++;
            $display("FAIL frame_period got %0d want %0d", cnt, SFRAME);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int unsigned th, tv;
        int guard;
        repeat (3) begin
            th = SHD + SHF + $urandom_range(SHR - 1);
            tv = $urandom_range(SVTOT - 1);
            guard = 0;
            e = model_s(n);
            while (!(e.x == 10'(th) && e.y == 10'(tv)) && guard < 2 * SFRAME) begin
                @(negedge clk);
                e = model_s(n);
                guard++;
            end
            checks++;
            if (s_hs !== 1'b0 || s_x !== 10'(th) || s_y !== 10'(tv)) begin
                errors++;
                $display("FAIL mid_reset_pre got hs=%b x=%0d y=%0d want hs=0 x=%0d y=%0d",
                         s_hs, s_x, s_y, th, tv);
            end
            reset = 1'b1;
            @(negedge clk);
            checks++;
            if ({s_x, s_y, s_hs, s_vs, s_pt, s_fs} !== {10'd0, 10'd0, 4'b1100}) begin
                errors++;
                $display("FAIL mid_reset got x=%0d y=%0d hs=%b vs=%b pt=%b fs=%b want 0 0 1 1 0 0",
                         s_x, s_y, s_hs, s_vs, s_pt, s_fs);
            end
            reset = 1'b0;
            repeat (3 * SDIV) begin
                @(negedge clk);
                e = model_s(n);
                checks++;
                if ({s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs} !== e) begin
                    errors++;
                    $display("FAIL mid_reset_restart n=%0d got %h want %h",
                             n, {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs}, e);
                end
            end
        end
    endtask

    task automatic test_random_run();
        exp_t e;
        int unsigned len;
        repeat (4) begin
            len = $urandom_range(1500, 50);
            repeat (len) begin
                @(negedge clk);
                e = model_s(n);
                checks++;
                if ({s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs} !== e) begin
                    errors++;
                    $display("FAIL random_run n=%0d got %h want %h",
                             n, {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs}, e);
                end
            end
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_tick_spacing();
        test_hsync_line();
        test_line_wrap();
        test_vsync();
        test_frame_wrap();
        test_mid_reset();
        test_random_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
